// File: rtl/arbiter_wb.sv
// arbiter_wb: two-master Wishbone arbiter with registered round-robin grants.
// Master 0 is the management CPU data bus, master 1 the debug/housekeeping master.
// Optional bus-cycle watchdog, enabled by defining ARBITER_WB_TIMEOUT_EN. When the
// watchdog fires it acks the stalled master with DEAD_BEEF and records the address.
module arbiter_wb #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int TO_W      = 8,
  parameter int TO_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rstn_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  output logic            to_flag_o,
  output logic [AW-1:0]   to_adr_o,
  input  logic            to_clr_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam logic [DW-1:0] DEAD_DAT = DW'(32'hDEAD_BEEF);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   fire;

  // Next grant: round-robin on ties, hold grant until the owner drops cyc
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_q) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_d = IDLE;
      GNT1:    if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant state and round-robin history
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Downstream mux: granted master's signals, all zero while idle
  always_comb begin
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_we_o  = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    case (state_q)
      GNT0: begin
        wbm_adr_o = m0_adr_i;
        wbm_dat_o = m0_dat_i;
        wbm_sel_o = m0_sel_i;
        wbm_we_o  = m0_we_i;
        wbm_cyc_o = m0_cyc_i;
        wbm_stb_o = m0_stb_i;
      end
      GNT1: begin
        wbm_adr_o = m1_adr_i;
        wbm_dat_o = m1_dat_i;
        wbm_sel_o = m1_sel_i;
        wbm_we_o  = m1_we_i;
        wbm_cyc_o = m1_cyc_i;
        wbm_stb_o = m1_stb_i;
      end
      default: ;
    endcase
  end

  // Upstream return path: ack/data pass straight through to the granted master only
  always_comb begin
    m0_ack_o = (state_q == GNT0) && m0_stb_i && (wbm_ack_i || fire);
    m1_ack_o = (state_q == GNT1) && m1_stb_i && (wbm_ack_i || fire);
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (state_q == GNT0) m0_dat_o = fire ? DEAD_DAT : wbm_dat_i;
    if (state_q == GNT1) m1_dat_o = fire ? DEAD_DAT : wbm_dat_i;
  end

`ifdef ARBITER_WB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            stalled;

  // Watchdog: count stalled strobe cycles, fire once the count hits the limit
  always_comb begin
    stalled = wbm_stb_o && !wbm_ack_i;
    fire    = stalled && (cnt_q == TO_W'(TO_CYCLES));
    cnt_d   = cnt_q + 1'b1;
    if (fire || !stalled || (state_d != state_q)) cnt_d = '0;
    flag_d  = flag_q;
    if (to_clr_i) flag_d = 1'b0;
    if (fire)     flag_d = 1'b1;
    adr_d   = fire ? wbm_adr_o : adr_q;
  end

  // Watchdog counter, sticky flag and captured address
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
      adr_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      adr_q  <= adr_d;
    end
  end

  assign to_flag_o = flag_q;
  assign to_adr_o  = adr_q;
`else
  logic unused_to_clr;
  assign unused_to_clr = to_clr_i;
  assign fire          = 1'b0;
  assign to_flag_o     = 1'b0;
  assign to_adr_o      = '0;
`endif

endmodule

// File: tb/tb_arbiter_wb.sv
// Directed bench for arbiter_wb: reset, single transfer, round-robin, burst,
// reset mid-transfer and watchdog behaviour (on or off depending on the build).
module tb_arbiter_wb;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] m0_adr, m1_adr, wbm_adr, to_adr;
  logic [DW-1:0] m0_dat, m1_dat, m0_dato, m1_dato, wbm_dat, wbm_dati;
  logic [3:0]    m0_sel, m1_sel, wbm_sel;
  logic          m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic          m0_ack, m1_ack, wbm_we, wbm_cyc, wbm_stb, wbm_acki;
  logic          to_flag, to_clr;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  arbiter_wb #(.DW(DW), .AW(AW), .TO_W(8), .TO_CYCLES(4)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_dato), .m0_ack_o(m0_ack),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_dato), .m1_ack_o(m1_ack),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_dat_i(wbm_dati), .wbm_ack_i(wbm_acki),
    .to_flag_o(to_flag), .to_adr_o(to_adr), .to_clr_i(to_clr)
  );

  // inputs change 1 time unit after the rising edge; checks happen at the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
    wbm_dati = '0; wbm_acki = 0; to_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    next_cycle();
    next_cycle();
    rstn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat, wbm_sel} !== '0)
      $display("FAIL reset_wbm: got cyc=%b stb=%b adr=%h want all 0", wbm_cyc, wbm_stb, wbm_adr);
    else pass_cnt++;
    total++;
    if ({m0_ack, m1_ack, m0_dato, m1_dato, to_flag, to_adr} !== '0)
      $display("FAIL reset_up: got ack=%b%b dat=%h/%h flag=%b toadr=%h want 0",
               m0_ack, m1_ack, m0_dato, m1_dato, to_flag, to_adr);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h2100_0004; m0_sel = 4'hF;
    @(negedge clk);
    total++;
    if (wbm_stb !== 1'b0) $display("FAIL single_req_cycle: stb=%b want 0", wbm_stb);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total++;
    if ({wbm_stb, wbm_cyc, wbm_adr, m0_ack} !== {1'b1, 1'b1, 32'h2100_0004, 1'b0})
      $display("FAIL single_grant: stb=%b cyc=%b adr=%h ack=%b want 1 1 21000004 0",
               wbm_stb, wbm_cyc, wbm_adr, m0_ack);
    else pass_cnt++;
    next_cycle();
    wbm_acki = 1; wbm_dati = 32'h1234_5678;
    @(negedge clk);
    total++;
    if ({m0_ack, m0_dato, m1_ack} !== {1'b1, 32'h1234_5678, 1'b0})
      $display("FAIL single_ack: ack0=%b dat0=%h ack1=%b want 1 12345678 0", m0_ack, m0_dato, m1_ack);
    else pass_cnt++;
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    total++;
    if ({wbm_cyc, wbm_stb, wbm_adr} !== '0)
      $display("FAIL single_release: cyc=%b stb=%b adr=%h want 0", wbm_cyc, wbm_stb, wbm_adr);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA000_0000;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB000_0000;
    next_cycle();
    @(negedge clk);
    total++;
    if (wbm_adr !== 32'hA000_0000) $display("FAIL rr_first_gnt0: adr=%h want a0000000", wbm_adr);
    else pass_cnt++;
    next_cycle();
    m0_cyc = 0; m0_stb = 0;
    next_cycle();
    @(negedge clk);
    total++;
    if ({wbm_cyc, wbm_adr} !== '0) $display("FAIL rr_idle_gap: cyc=%b adr=%h want 0", wbm_cyc, wbm_adr);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total++;
    if ({wbm_cyc, wbm_adr} !== {1'b1, 32'hB000_0000})
      $display("FAIL rr_gnt1: cyc=%b adr=%h want 1 b0000000", wbm_cyc, wbm_adr);
    else pass_cnt++;
    m1_cyc = 0; m1_stb = 0;
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({wbm_cyc, wbm_adr} !== {1'b1, 32'hA000_0000})
      $display("FAIL rr_regrant0: cyc=%b adr=%h want 1 a0000000", wbm_cyc, wbm_adr);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_1000;
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hCCCC_0000;
    for (int i = 0; i < 4; i++) begin
      m1_adr = 32'h0000_1000 + 32'(i * 4);
      wbm_acki = 1; wbm_dati = 32'h5555_0000 + 32'(i);
      @(negedge clk);
      total++;
      if ({m1_ack, m1_dato, wbm_adr, m0_ack} !== {1'b1, 32'h5555_0000 + 32'(i), 32'h0000_1000 + 32'(i * 4), 1'b0})
        $display("FAIL burst_beat%0d: ack1=%b dat1=%h adr=%h ack0=%b", i, m1_ack, m1_dato, wbm_adr, m0_ack);
      else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h4000_0010;
    next_cycle();
    @(negedge clk);
    total++;
    if (wbm_stb !== 1'b1) $display("FAIL rmid_grant: stb=%b want 1", wbm_stb);
    else pass_cnt++;
    next_cycle();
    rstn = 0;
    next_cycle();
    wbm_acki = 1; wbm_dati = 32'h9999_9999;
    @(negedge clk);
    total++;
    if ({wbm_cyc, wbm_stb, wbm_adr, m1_ack, m1_dato, to_flag} !== '0)
      $display("FAIL rmid_outputs: cyc=%b stb=%b adr=%h ack1=%b dat1=%h want 0",
               wbm_cyc, wbm_stb, wbm_adr, m1_ack, m1_dato);
    else pass_cnt++;
    next_cycle();
    wbm_acki = 0;
    rstn = 1;
    @(negedge clk);
    total++;
    if (wbm_stb !== 1'b0) $display("FAIL rmid_idle_after: stb=%b want 0", wbm_stb);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total++;
    if ({wbm_stb, wbm_adr} !== {1'b1, 32'h4000_0010})
      $display("FAIL rmid_regrant: stb=%b adr=%h want 1 40000010", wbm_stb, wbm_adr);
    else pass_cnt++;
    idle_inputs();
    next_cycle();
  endtask

`ifdef ARBITER_WB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h3000_0000;
    next_cycle();
    // four stalled cycles with counter 0..3, then the fire cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (m0_ack !== 1'b0) $display("FAIL to_early_ack%0d: ack=%b want 0", i, m0_ack);
      else pass_cnt++;
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({m0_ack, m0_dato, to_flag} !== {1'b1, 32'hDEAD_BEEF, 1'b0})
      $display("FAIL to_fire: ack=%b dat=%h flag=%b want 1 deadbeef 0", m0_ack, m0_dato, to_flag);
    else pass_cnt++;
    next_cycle();
    idle_inputs();
    to_clr = 1;
    @(negedge clk);
    total++;
    if ({to_flag, to_adr, m0_ack} !== {1'b1, 32'h3000_0000, 1'b0})
      $display("FAIL to_flag_set: flag=%b adr=%h ack=%b want 1 30000000 0", to_flag, to_adr, m0_ack);
    else pass_cnt++;
    next_cycle();
    to_clr = 0;
    @(negedge clk);
    total++;
    if (to_flag !== 1'b0) $display("FAIL to_flag_clr: flag=%b want 0", to_flag);
    else pass_cnt++;
  endtask
`else
  task automatic test_no_timeout();
    int acks = 0;
    int flags = 0;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_0000;
    to_clr = 0;
    next_cycle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m1_ack || m0_ack) acks++;
      if (to_flag || (to_adr != '0)) flags++;
      next_cycle();
    end
    total++;
    if (acks !== 0) $display("FAIL noto_acks: got %0d acks want 0", acks);
    else pass_cnt++;
    total++;
    if (flags !== 0) $display("FAIL noto_flag: got %0d flagged cycles want 0", flags);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({wbm_stb, wbm_adr} !== {1'b1, 32'h3000_0000})
      $display("FAIL noto_still_granted: stb=%b adr=%h want 1 30000000", wbm_stb, wbm_adr);
    else pass_cnt++;
    idle_inputs();
    next_cycle();
  endtask
`endif

  initial begin
    idle_inputs();
    rstn = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
`ifdef ARBITER_WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
